alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer that shares the single 8-bit combinational ALU between two requesters (e.g. the execute stage and a debug/loader port). It accepts one operation at a time with a valid/ready handshake, drives the ALU opcode and operands for a fixed settle window, captures the result and the ZERO/NEG flags, and returns them to the winning requester with a one-cycle response pulse. A NOP is driven between operations so back-to-back identical opcodes always produce an opcode transition at the ALU.

## Interface
- SETTLE, 1, number of cycles operands/opcode are held before result capture; legal 1..15
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  (N=0,1) request present
- reqN_op  in  3  opcode: 000 NOP, 001 ADD, 010 SUB, 011 NAND, 100 SHL, 101 SHR; 110/111 illegal
- reqN_a, reqN_b  in  8  signed operands
- reqN_ready  out  1  request accepted when valid&ready at a rising edge
- rspN_valid  out  1  one-cycle response pulse
- rspN_result  out  8  captured ALU result
- rspN_zero, rspN_neg  out  1  captured flags
- rspN_err  out  1  illegal opcode reported
- alu_op  out  3  to ALU opcode input
- alu_a, alu_b  out  8  to ALU operand inputs
- alu_result  in  8; alu_zero, alu_neg  in  1  from ALU

## Operation
- States: IDLE, ISSUE, RESP. Reset state IDLE.
- IDLE: alu_op=000, alu_a=alu_b=0. If any reqN_valid, winner selected combinationally; only winner's reqN_ready=1. On the edge, latch op/a/b/winner ID, go ISSUE (legal opcode) or RESP with err (110/111, and 000).
- ISSUE: drive alu_op/alu_a/alu_b from latched values; settle counter counts SETTLE cycles; on the edge ending the last cycle capture alu_result/alu_zero/alu_neg into winner's response registers, go RESP.
- RESP: alu_op=000, operands 0; winner's rspN_valid=1 for exactly this cycle; go IDLE.
- Request opcode 000: accepted, not issued; response result 0, zero=0, neg=0, err=0. Opcodes 110/111: same but err=1.
- rspN_result/flags/err hold their last value between responses; only rspN_valid pulses. The non-winning port's response registers are unchanged.
- reqN_ready is 0 in ISSUE and RESP; requesters hold valid and payload until accepted.
- Arbitration on simultaneous valid: see Configuration. A single valid requester is always granted in IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; last-grant pointer = 1 (port 0 wins first tie).
- Accept-to-rsp_valid latency: SETTLE+1 cycles for legal ops, 1 cycle for NOP/illegal.
- Throughput: one legal op per SETTLE+2 cycles; new accept possible in the cycle after RESP.
- alu_op transitions through 000 between any two issued operations.
- Reset asserted mid-operation: immediate return to IDLE, in-flight op dropped, no response pulse, response registers cleared.
- Requester dropping valid before ready: no transfer, no error.

## Configuration
- ALU_ARB_RR_EN defined: round-robin; on a tie the port not granted most recently wins; pointer updates on every accept.
- Not defined: fixed priority; port 0 always wins ties; pointer logic absent.

## Test plan
- Reset: rst_n low mid-ISSUE of ADD 5+3 -> all outputs 0 immediately, no rsp0_valid after release.
- Single op, SETTLE=1: req0 ADD a=5 b=3 -> alu_op=001 one cycle, rsp0_valid 2 cycles after accept, result 8, zero 0, neg 0.
- Flags: req1 SUB a=3 b=5 -> rsp1_result 0xFE, neg 1; req1 SUB a=4 b=4 -> result 0, zero 1.
- Tie, both valid with ADD/NAND continuously: RR_EN -> grants alternate 0,1,0,1; without -> port 0 granted every time until it drops valid.
- Back-to-back identical SHL a=0x41 from port 0 -> alu_op sequence 100,000,100; both results 0x82.
- Illegal op 111 on port 1 -> alu_op stays 000, rsp1_valid 1 cycle after accept, err 1, result 0; SETTLE=4 legal op latency 5 cycles.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port valid/ready sequencer sharing one combinational 8-bit ALU.
// Tie-break is fixed priority (port 0) unless ALU_ARB_RR_EN is defined, which selects round-robin.
module alu_arbiter #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid_i,
  input  logic [2:0] req0_op_i,
  input  logic [7:0] req0_a_i,
  input  logic [7:0] req0_b_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [2:0] req1_op_i,
  input  logic [7:0] req1_a_i,
  input  logic [7:0] req1_b_i,
  output logic       req1_ready_o,
  output logic       rsp0_valid_o,
  output logic [7:0] rsp0_result_o,
  output logic       rsp0_zero_o,
  output logic       rsp0_neg_o,
  output logic       rsp0_err_o,
  output logic       rsp1_valid_o,
  output logic [7:0] rsp1_result_o,
  output logic       rsp1_zero_o,
  output logic       rsp1_neg_o,
  output logic       rsp1_err_o,
  output logic [2:0] alu_op_o,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  input  logic [7:0] alu_result_i,
  input  logic       alu_zero_i,
  input  logic       alu_neg_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  localparam logic [3:0] LAST = 4'(SETTLE - 1);
  state_e     state_q;
  logic [3:0] cnt_q;
  logic       win_q;
  logic [2:0] alu_op_q;
  logic [7:0] alu_a_q, alu_b_q;
  logic [1:0] vld_q, zero_q, neg_q, err_q;
  logic [7:0] res_q [2];
  logic       any, win, tie_win, legal, idle;
  logic [2:0] sel_op;
  logic [7:0] sel_a, sel_b;
`ifdef ALU_ARB_RR_EN
  logic ptr_q;
  assign tie_win = ~ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= 1'b1;
    else if (idle && any) ptr_q <= win;
`else
  assign tie_win = 1'b0;
`endif
  always_comb begin
    idle   = state_q == IDLE;
    any    = req0_valid_i | req1_valid_i;
    win    = req1_valid_i & (~req0_valid_i | tie_win);
    sel_op = win ? req1_op_i : req0_op_i;
    sel_a  = win ? req1_a_i : req0_a_i;
    sel_b  = win ? req1_b_i : req0_b_i;
    legal  = sel_op != 3'b000 && sel_op[2:1] != 2'b11;
  end
  assign req0_ready_o = idle & req0_valid_i & ~win;
  assign req1_ready_o = idle & req1_valid_i & win;
  // NOP and illegal opcodes skip ISSUE entirely, so the ALU never sees them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= 1'b0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      vld_q    <= '0;
      zero_q   <= '0;
      neg_q    <= '0;
      err_q    <= '0;
      res_q[0] <= '0;
      res_q[1] <= '0;
    end else begin
      case (state_q)
        IDLE: if (any) begin
          win_q <= win;
          cnt_q <= '0;
          if (legal) begin
            state_q  <= ISSUE;
            alu_op_q <= sel_op;
            alu_a_q  <= sel_a;
            alu_b_q  <= sel_b;
          end else begin
            state_q     <= RESP;
            vld_q[win]  <= 1'b1;
            res_q[win]  <= '0;
            zero_q[win] <= 1'b0;
            neg_q[win]  <= 1'b0;
            err_q[win]  <= sel_op[2] & sel_op[1];
          end
        end
        ISSUE: if (cnt_q == LAST) begin
          state_q       <= RESP;
          alu_op_q      <= '0;
          alu_a_q       <= '0;
          alu_b_q       <= '0;
          vld_q[win_q]  <= 1'b1;
          res_q[win_q]  <= alu_result_i;
          zero_q[win_q] <= alu_zero_i;
          neg_q[win_q]  <= alu_neg_i;
          err_q[win_q]  <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
        RESP: begin
          state_q <= IDLE;
          vld_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign alu_op_o      = alu_op_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign rsp0_valid_o  = vld_q[0];
  assign rsp0_result_o = res_q[0];
  assign rsp0_zero_o   = zero_q[0];
  assign rsp0_neg_o    = neg_q[0];
  assign rsp0_err_o    = err_q[0];
  assign rsp1_valid_o  = vld_q[1];
  assign rsp1_result_o = res_q[1];
  assign rsp1_zero_o   = zero_q[1];
  assign rsp1_neg_o    = neg_q[1];
  assign rsp1_err_o    = err_q[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors with a response scoreboard; a SETTLE=1 and a SETTLE=4 instance.
module tb_alu_arbiter;
  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, NAND = 3'd3, SHL = 3'd4, ILL = 3'd7;
  typedef struct {
    logic       port;
    logic [7:0] res;
    logic       z, n, e;
    int         acc;
    int         lat;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int cyc = 0, nvec = 0, nerr = 0;
  exp_t q1[$], q4[$];
  exp_t m1, m4;
  logic [2:0] oplog[$];
  logic [2:0] last_op = '0;
  bit log_en = 1'b0;
  logic       v0 = 0, v1 = 0, rdy0, rdy1, rv0, rv1, rz0, rz1, rn0, rn1, re0, re1, az, an;
  logic [2:0] op0 = 0, op1 = 0, aop;
  logic [7:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0, rr0, rr1, aa, ab, ares;
  logic       tv0 = 0, tv1 = 0, trdy0, trdy1, trv0, trv1, trz0, trz1, trn0, trn1, tre0, tre1, taz, tan;
  logic [2:0] top0 = 0, top1 = 0, taop;
  logic [7:0] ta0 = 0, ta1 = 0, tb0 = 0, tb1 = 0, trr0, trr1, taa, tab, tares;
  logic [44:0] all_out;
  assign all_out = {rdy0, rdy1, rv0, rv1, rr0, rr1, rz0, rz1, rn0, rn1, re0, re1, aop, aa, ab};
  function automatic logic [9:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = op == ADD ? a + b : op == SUB ? a - b : op == NAND ? ~(a & b) :
        op == SHL ? {a[6:0], 1'b0} : op == 3'd5 ? {1'b0, a[7:1]} : 8'h00;
    return {r, r == 8'h00, r[7]};
  endfunction
  assign {ares, az, an}   = alu(aop, aa, ab);
  assign {tares, taz, tan} = alu(taop, taa, tab);
  alu_arbiter #(.SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(v0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(rdy0),
    .req1_valid_i(v1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(rdy1),
    .rsp0_valid_o(rv0), .rsp0_result_o(rr0), .rsp0_zero_o(rz0), .rsp0_neg_o(rn0), .rsp0_err_o(re0),
    .rsp1_valid_o(rv1), .rsp1_result_o(rr1), .rsp1_zero_o(rz1), .rsp1_neg_o(rn1), .rsp1_err_o(re1),
    .alu_op_o(aop), .alu_a_o(aa), .alu_b_o(ab), .alu_result_i(ares), .alu_zero_i(az), .alu_neg_i(an)
  );
  alu_arbiter #(.SETTLE(4)) u_s4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(tv0), .req0_op_i(top0), .req0_a_i(ta0), .req0_b_i(tb0), .req0_ready_o(trdy0),
    .req1_valid_i(tv1), .req1_op_i(top1), .req1_a_i(ta1), .req1_b_i(tb1), .req1_ready_o(trdy1),
    .rsp0_valid_o(trv0), .rsp0_result_o(trr0), .rsp0_zero_o(trz0), .rsp0_neg_o(trn0), .rsp0_err_o(tre0),
    .rsp1_valid_o(trv1), .rsp1_result_o(trr1), .rsp1_zero_o(trz1), .rsp1_neg_o(trn1), .rsp1_err_o(tre1),
    .alu_op_o(taop), .alu_a_o(taa), .alu_b_o(tab), .alu_result_i(tares), .alu_zero_i(taz), .alu_neg_i(tan)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic chk_rsp(input string nm, input exp_t e, input logic p, input logic [7:0] r,
                         input logic z, input logic n, input logic er, input int lat);
    check({nm, "_port_res_z_n_err"}, {p, r, z, n, er}, {e.port, e.res, e.z, e.n, e.e});
    check({nm, "_latency"}, lat, e.lat);
  endtask
  task automatic unexpected(input string nm, input logic p0, input logic p1);
    nvec++;
    nerr++;
    $display("FAIL %s: rsp0_valid=%0b rsp1_valid=%0b, expected no response", nm, p0, p1);
  endtask
  always @(negedge clk) if (rst_n && (rv0 || rv1)) begin
    if (rv0 && rv1) unexpected("s1_both_valid", rv0, rv1);
    else if (q1.size() == 0) unexpected("s1_unexpected_rsp", rv0, rv1);
    else begin
      m1 = q1.pop_front();
      chk_rsp("s1", m1, rv1, rv1 ? rr1 : rr0, rv1 ? rz1 : rz0, rv1 ? rn1 : rn0, rv1 ? re1 : re0, cyc - m1.acc);
    end
  end
  always @(negedge clk) if (rst_n && (trv0 || trv1)) begin
    if (trv1 || q4.size() == 0) unexpected("s4_unexpected_rsp", trv0, trv1);
    else begin
      m4 = q4.pop_front();
      chk_rsp("s4", m4, 1'b0, trr0, trz0, trn0, tre0, cyc - m4.acc);
    end
  end
  always @(negedge clk) if (log_en && aop !== last_op) begin
    oplog.push_back(aop);
    last_op = aop;
  end
  task automatic set_req(input bit d, input bit p, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (d) begin tv0 = v; top0 = op; ta0 = a; tb0 = b; end
    else if (p) begin v1 = v; op1 = op; a1 = a; b1 = b; end
    else begin v0 = v; op0 = op; a0 = a; b0 = b; end
  endtask
  task automatic wait_rdy(input bit d, input logic [1:0] m, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      #1;
      if (((d ? {trdy1, trdy0} : {rdy1, rdy0}) & m) != 2'b00) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      nvec++;
      nerr++;
      $display("FAIL ready_timeout: no ready within 40 cycles, expected grant mask %b", m);
    end
  endtask
  task automatic go(input bit d, input bit p, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] r, input logic z, input logic n, input logic e, input int lat);
    bit ok;
    exp_t x;
    @(negedge clk);
    set_req(d, p, 1'b1, op, a, b);
    wait_rdy(d, p ? 2'b10 : 2'b01, ok);
    if (ok) begin
      @(posedge clk);
      x = '{p, r, z, n, e, cyc, lat};
      if (d) q4.push_back(x);
      else q1.push_back(x);
    end
    #1 set_req(d, p, 1'b0, 3'd0, 8'd0, 8'd0);
  endtask
  task automatic drain();
    for (int k = 0; k < 80 && (q1.size() + q4.size()) != 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if ((q1.size() + q4.size()) != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q1.size() + q4.size());
      q1.delete();
      q4.delete();
    end
  endtask
  task automatic log_start();
    oplog.delete();
    last_op = '0;
    log_en = 1'b1;
  endtask
  task automatic log_chk(input string nm, input int n, input logic [11:0] exp);
    logic [11:0] act = '0;
    log_en = 1'b0;
    for (int i = 0; i < oplog.size() && i < 4; i++) act[11 - 3*i -: 3] = oplog[i];
    check({nm, "_count"}, oplog.size(), n);
    check({nm, "_seq"}, act, exp);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok, p;
    logic [3:0] tie;
    exp_t x;
`ifdef ALU_ARB_RR_EN
    tie = 4'b1010;
`else
    tie = 4'b0000;
`endif
    repeat (3) @(negedge clk);
    check("reset_outputs", all_out, 45'd0);
    rst_n = 1'b1;
    log_start();
    go(0, 0, ADD, 8'd5, 8'd3, 8'h08, 0, 0, 0, 2);
    drain();
    log_chk("add_alu_op", 2, {3'd1, 3'd0, 3'd0, 3'd0});
    go(0, 1, SUB, 8'd3, 8'd5, 8'hFE, 0, 1, 0, 2);
    go(0, 1, SUB, 8'd4, 8'd4, 8'h00, 1, 0, 0, 2);
    drain();
    check("port0_hold", {rr0, rz0, rn0, re0}, {8'h08, 3'b000});
    log_start();
    go(0, 0, SHL, 8'h41, 8'h00, 8'h82, 0, 1, 0, 2);
    go(0, 0, SHL, 8'h41, 8'h00, 8'h82, 0, 1, 0, 2);
    drain();
    log_chk("shl_b2b_alu_op", 4, {3'd4, 3'd0, 3'd4, 3'd0});
    go(0, 0, NOP, 8'd7, 8'd7, 8'h00, 0, 0, 0, 1);
    drain();
    log_start();
    go(0, 1, ILL, 8'd9, 8'd9, 8'h00, 0, 0, 1, 1);
    drain();
    log_chk("illegal_alu_op", 0, 12'd0);
    @(negedge clk);
    set_req(0, 0, 1'b1, ADD, 8'd1, 8'd1);
    set_req(0, 1, 1'b1, NAND, 8'hFF, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      p = i == 4 ? 1'b1 : tie[i];
      if (i == 4) set_req(0, 0, 1'b0, 3'd0, 8'd0, 8'd0);
      wait_rdy(0, 2'b11, ok);
      if (ok) begin
        check("tie_grant", {rdy1, rdy0}, p ? 2'b10 : 2'b01);
        @(posedge clk);
        x = p ? '{1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, cyc, 2} : '{1'b0, 8'h02, 1'b0, 1'b0, 1'b0, cyc, 2};
        q1.push_back(x);
        @(negedge clk);
      end
    end
    set_req(0, 1, 1'b0, 3'd0, 8'd0, 8'd0);
    drain();
    go(1, 0, ADD, 8'd5, 8'd3, 8'h08, 0, 0, 0, 5);
    drain();
    @(negedge clk);
    set_req(0, 0, 1'b1, ADD, 8'd5, 8'd3);
    wait_rdy(0, 2'b01, ok);
    @(posedge clk);
    #1 set_req(0, 0, 1'b0, 3'd0, 8'd0, 8'd0);
    @(negedge clk);
    check("mid_issue_alu_op", aop, ADD);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", all_out, 45'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_outputs", all_out, 45'd0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
